uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares one UART transmitter among NREQ byte requesters with round-robin arbitration.
//  Sits between client blocks and the transmitter, driving its txstart/txdin and consuming txdone.
//  Enforces a minimum idle gap between frames and runs a watchdog that recovers from a missing txdone.
// PARAMETERS
//  DBIT          8     data bits per frame; must match the transmitter's dbit
//  NREQ          4     number of requesters, >=2
//  GAP_CYCLES    16    idle clk cycles forced after each frame; 0 = no gap state
//  TIMEOUT_CYC   4096  clk cycles allowed in WAIT before abort; >=2
// PORTS
//  clk        in   1            system clock, rising edge
//  reset_n    in   1            asynchronous active-low reset
//  req        in   NREQ         req[i]=1: requester i has a byte; held until ack[i] or err pulse
//  req_data   in   NREQ*DBIT    byte of requester i at [i*DBIT +: DBIT]; stable while req[i]=1
//  ack        out  NREQ         one-cycle pulse: requester i's frame completed (txdone seen)
//  err        out  1            one-cycle pulse: watchdog abort of the current frame
//  grant_id   out  clog2(NREQ)  index of the requester owning the transmitter (valid while busy)
//  busy       out  1            1 in START/WAIT/GAP
//  txstart    out  1            one-cycle start pulse to the transmitter
//  txdin      out  DBIT         byte to the transmitter; registered, held from START to WAIT exit
//  txdone     in   1            one-cycle completion pulse from the transmitter
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; round-robin pointer rr=0; counters 0. Reset may assert at any time.
//   Mid-frame it returns to IDLE with no ack or err; the transmitter shares reset_n.
//  All outputs are registered. States: IDLE, START, WAIT, GAP.
//  IDLE: if |req, grant the first i with req[i]=1, searching from rr upward with wrap.
//   At the same edge: latch txdin<=req_data[i], grant_id<=i, rr<=(i+1)%NREQ, go to START.
//  START: txstart=1 for exactly this one cycle; go to WAIT; watchdog counter wcnt<=0.
//  WAIT: txstart=0.
//   - On txdone=1: ack[grant_id]=1 next cycle (one cycle), then GAP, or IDLE if GAP_CYCLES=0.
//   - Else, on wcnt==TIMEOUT_CYC-1: err=1 (one cycle), no ack, same exit as txdone.
//   - Else wcnt<=wcnt+1.
//   - txdone and timeout in the same cycle: txdone wins (ack, no err).
//   - req[grant_id] dropping during WAIT is ignored: the frame completes and ack is still issued.
//  GAP: count GAP_CYCLES cycles, then IDLE. req is not sampled in GAP.
//  Timing: first txstart is 2 cycles after req rises (IDLE grant edge, then START).
//   Back-to-back frames are separated by ack cycle + GAP_CYCLES + 1 arbitration cycle.
//  txdone outside WAIT is ignored. An errored requester keeps req high and is retried in round-robin order.
//  Fairness: with all req high, grants cycle 0,1,..,NREQ-1,0,... No requester waits more than NREQ-1 frames.
//  Counter widths: wcnt clog2(TIMEOUT_CYC), gap counter clog2(GAP_CYCLES+1). No wrap beyond terminal count.
// TESTING
//  1 Single req[2]=1, data 8'hA5 -> txstart 2 cycles later, txdin=A5, grant_id=2; txdone -> ack[2] pulse;
//     serial line shows A5 LSB-first.
//  2 All req high, distinct bytes 11,22,33,44 -> txstart order 0,1,2,3,0. Each frame is followed by
//     >= GAP_CYCLES idle cycles before the next txstart.
//  3 txdone tied low, TIMEOUT_CYC=32 -> err pulses exactly 32 cycles after WAIT entry, no ack.
//     The same requester is regranted in turn.
//  4 Force txdone on the exact timeout cycle -> ack pulse, err stays 0.
//  5 reset_n low mid-WAIT -> all outputs 0 immediately. After release, a pending req is granted from rr=0.
//  6 req[1] dropped during WAIT -> ack[1] still pulses on txdone; no extra txstart for requester 1.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin scheduler sharing one UART transmitter among NREQ requesters
module uart_tx_scheduler #(
    parameter int DBIT        = 8,
    parameter int NREQ        = 4,
    parameter int GAP_CYCLES  = 16,
    parameter int TIMEOUT_CYC = 4096,
    localparam int IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DBIT-1:0] req_data,
    output logic [NREQ-1:0]      ack,
    output logic                 err,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy,
    output logic                 txstart,
    output logic [DBIT-1:0]      txdin,
    input  logic                 txdone
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam int WW = $clog2(TIMEOUT_CYC);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    // Terminal counts; GAP_LAST is never reached when the gap state is unused.
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    logic [1:0]      r_state;
    logic [IDW-1:0]  r_rr;
    logic [WW-1:0]   r_wcnt;
    logic [GW-1:0]   r_gcnt;
    logic [NREQ-1:0] r_ack;
    logic            r_err;
    logic [IDW-1:0]  r_grant_id;
    logic            r_busy;
    logic            r_txstart;
    logic [DBIT-1:0] r_txdin;

    logic            w_found;
    logic [IDW-1:0]  w_pick;
    logic [IDW-1:0]  w_rr_next;
    logic [DBIT-1:0] w_data;

    // Round-robin search: first requester at or above the pointer, wrapping at NREQ.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_pick  = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(r_rr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_pick  = IDW'(idx);
            end
        end
    end

    assign w_rr_next = (w_pick == IDW'(NREQ - 1)) ? '0 : w_pick + 1'b1;
    assign w_data    = req_data[int'(w_pick)*DBIT +: DBIT];

    // Arbitration, frame sequencing, watchdog and inter-frame gap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_rr       <= '0;
            r_wcnt     <= '0;
            r_gcnt     <= '0;
            r_ack      <= '0;
            r_err      <= 1'b0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
            r_txstart  <= 1'b0;
            r_txdin    <= '0;
        end else begin
            r_txstart <= 1'b0;
            r_ack     <= '0;
            r_err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_txdin    <= w_data;
                        r_grant_id <= w_pick;
                        r_rr       <= w_rr_next;
                        r_busy     <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_txstart <= 1'b1;
                    r_wcnt    <= '0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    // txdone has priority over a simultaneous watchdog expiry.
                    if (txdone || (r_wcnt == WAIT_LAST)) begin
                        if (txdone) begin
                            r_ack <= NREQ'(1) << r_grant_id;
                        end else begin
                            r_err <= 1'b1;
                        end
                        if (GAP_CYCLES == 0) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_gcnt  <= '0;
                            r_state <= S_GAP;
                        end
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gcnt == GAP_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gcnt <= r_gcnt + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack      = r_ack;
    assign err      = r_err;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;
    assign txstart  = r_txstart;
    assign txdin    = r_txdin;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

    localparam int DBIT = 8;
    localparam int NREQ = 4;
    localparam int GAP  = 5;
    localparam int TO   = 32;

    localparam int W_START = 0;
    localparam int W_ACK   = 1;
    localparam int W_ERR   = 2;
    localparam int W_DONE  = 3;
    localparam int W_IDLE  = 4;

    logic                 clk;
    logic                 reset_n;
    logic [NREQ-1:0]      req;
    logic [NREQ*DBIT-1:0] req_data;
    logic [NREQ-1:0]      ack;
    logic                 err;
    logic [1:0]           grant_id;
    logic                 busy;
    logic                 txstart;
    logic [DBIT-1:0]      txdin;
    logic                 txdone;

    int n_pass  = 0;
    int n_total = 0;

    // transmitter emulation controls
    int tx_mode = 0;   // 0 fixed delay, 1 never done, 2 done on timeout cycle, 3 random delay
    int fixed_k = 3;
    bit spur_en = 0;
    int emu_k;

    // behavioural model: frame timeline in edge numbers
    int  m_n, m_g, m_e, m_free, m_owner, m_rr;
    bit  m_active, m_has_end;
    logic [NREQ-1:0] e_ack;
    logic            e_err, e_busy, e_txstart;
    logic [1:0]      e_gid;
    logic [DBIT-1:0] e_txdin;

    uart_tx_scheduler #(
        .DBIT(DBIT), .NREQ(NREQ), .GAP_CYCLES(GAP), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
        .ack(ack), .err(err), .grant_id(grant_id), .busy(busy),
        .txstart(txstart), .txdin(txdin), .txdone(txdone)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_n = 0; m_g = 0; m_e = 0; m_free = 0; m_owner = 0; m_rr = 0;
        m_active = 0; m_has_end = 0;
        e_ack = '0; e_err = 0; e_busy = 0; e_txstart = 0; e_gid = '0; e_txdin = '0;
    endtask

    task automatic end_frame();
        m_active  = 0;
        m_has_end = 1;
        m_e       = m_n;
        m_free    = m_n + GAP + 1;
    endtask

    // One clock edge of the model: a frame granted at edge g pulses txstart after g+1,
    // watches txdone from edge g+2, and times out at edge g+TO+1; arbitration resumes GAP+1 edges later.
    task automatic model_step();
        bit found;
        m_n++;
        e_ack = '0; e_err = 0; e_txstart = 0;
        if (m_active) begin
            if (m_n == m_g + 1) e_txstart = 1;
            if (m_n >= m_g + 2) begin
                if (txdone) begin
                    e_ack[m_owner] = 1'b1;
                    end_frame();
                end else if (m_n == m_g + TO + 1) begin
                    e_err = 1'b1;
                    end_frame();
                end
            end
        end else if (m_n >= m_free && req != '0) begin
            found = 0;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && req[(m_rr + k) % NREQ]) begin
                    found   = 1;
                    m_owner = (m_rr + k) % NREQ;
                end
            end
            m_g      = m_n;
            m_active = 1;
            e_gid    = 2'(m_owner);
            e_txdin  = req_data[m_owner*DBIT +: DBIT];
            m_rr     = (m_owner + 1) % NREQ;
        end
        e_busy = m_active || (m_has_end && (m_n < m_e + GAP));
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    // compare DUT outputs against the model every cycle, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            check("busy", busy, e_busy);
            check("txstart", txstart, e_txstart);
            check("ack", ack, e_ack);
            check("err", err, e_err);
            check("grant_id", grant_id, e_gid);
            check("txdin", txdin, e_txdin);
        end
    end

    // transmitter emulation: answers each txstart with a txdone pulse after a mode-dependent delay
    initial begin
        txdone = 1'b0;
        forever begin
            @(negedge clk);
            if (txstart && reset_n && tx_mode != 1) begin
                if (tx_mode == 0) emu_k = fixed_k;
                else if (tx_mode == 2) emu_k = TO - 1;
                else emu_k = $urandom_range(0, 40);
                repeat (emu_k) @(posedge clk);
                #1 txdone = 1'b1;
                @(posedge clk);
                #1 txdone = 1'b0;
            end else if (spur_en && $urandom_range(0, 19) == 0) begin
                @(posedge clk);
                #1 txdone = 1'b1;
                @(posedge clk);
                #1 txdone = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic wait_for(input int what, input int maxc, output int n, output bit saw_ack, output bit saw_err);
        bit hit;
        hit = 0; saw_ack = 0; saw_err = 0; n = 0;
        while (!hit && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
            if (ack != '0) saw_ack = 1;
            if (err) saw_err = 1;
            case (what)
                W_START: hit = txstart;
                W_ACK:   hit = (ack != '0);
                W_ERR:   hit = err;
                W_DONE:  hit = (ack != '0) || err;
                W_IDLE:  hit = !busy;
                default: hit = 1;
            endcase
        end
        if (!hit) check($sformatf("wait_%0d_bound", what), 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        int  n, cnt;
        bit  sa, se;
        reset_n  = 1'b0;
        req      = '0;
        req_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_txstart", txstart, 0);
        check("rst_ack", ack, 0);
        check("rst_err", err, 0);
        check("rst_gid", grant_id, 0);
        check("rst_txdin", txdin, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // single requester 2
        tx_mode = 0; fixed_k = 3;
        req_data[2*DBIT +: DBIT] = 8'hA5;
        req = 4'b0100;
        wait_for(W_START, 10, n, sa, se);
        check("t1_latency", n, 2);
        check("t1_txdin", txdin, 8'hA5);
        check("t1_gid", grant_id, 2);
        check("t1_model_gid", e_gid, 2);
        wait_for(W_ACK, 60, n, sa, se);
        check("t1_ack", ack, 4'b0100);
        req = '0;
        wait_for(W_IDLE, 100, n, sa, se);

        // all requesters: order 0,1,2,3,0 and gap spacing
        do_reset();
        fixed_k  = 4;
        req_data = 32'h44332211;
        req      = 4'hF;
        for (int j = 0; j < 5; j++) begin
            wait_for(W_START, 100, n, sa, se);
            if (j > 0) check("t2_gap", n, GAP + 2);
            check("t2_gid", grant_id, j % 4);
            check("t2_txdin", txdin, ((j % 4) + 1) * 17);
            wait_for(W_ACK, 60, n, sa, se);
        end
        req = '0;
        wait_for(W_IDLE, 100, n, sa, se);

        // watchdog timeout and retry
        tx_mode = 1;
        req_data[DBIT +: DBIT] = 8'h3C;
        req = 4'b0010;
        wait_for(W_START, 100, n, sa, se);
        wait_for(W_ERR, 100, n, sa, se);
        check("t3_err_delay", n, TO);
        check("t3_no_ack", sa, 0);
        wait_for(W_START, 100, n, sa, se);
        check("t3_regrant", grant_id, 1);
        check("t3_model_regrant", e_gid, 1);
        req = '0;
        wait_for(W_ERR, 100, n, sa, se);
        wait_for(W_IDLE, 100, n, sa, se);

        // txdone on the exact timeout cycle
        tx_mode = 2;
        req_data[0 +: DBIT] = 8'h5A;
        req = 4'b0001;
        wait_for(W_START, 100, n, sa, se);
        wait_for(W_DONE, 100, n, sa, se);
        check("t4_ack", ack, 4'b0001);
        check("t4_err", err, 0);
        check("t4_delay", n, TO);
        req = '0;
        wait_for(W_IDLE, 100, n, sa, se);

        // reset mid-WAIT, then arbitration restarts from requester 0
        tx_mode = 1;
        req = 4'b0010;
        wait_for(W_START, 100, n, sa, se);
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("t5_rst_outputs", {ack, err, grant_id, busy, txstart, txdin}, 0);
        req_data[3*DBIT +: DBIT] = 8'h77;
        req = 4'b1010;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        wait_for(W_START, 10, n, sa, se);
        check("t5_latency", n, 2);
        check("t5_gid", grant_id, 1);
        req = '0;
        do_reset();

        // requester drops req during WAIT
        tx_mode = 0; fixed_k = 10;
        req_data[DBIT +: DBIT] = 8'hC3;
        req = 4'b0010;
        wait_for(W_START, 100, n, sa, se);
        req = '0;
        wait_for(W_ACK, 60, n, sa, se);
        check("t6_ack", ack, 4'b0010);
        cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (txstart) cnt++;
        end
        check("t6_no_restart", cnt, 0);

        // randomized traffic with spurious txdone, random delays and rare resets
        tx_mode = 3; spur_en = 1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && ack[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 7) == 0) begin
                    req_data[i*DBIT +: DBIT] = 8'($urandom);
                    req[i] = 1'b1;
                end
            end
            if (err && $urandom_range(0, 1) == 0) req[grant_id] = 1'b0;
            if (busy && $urandom_range(0, 199) == 0) req[grant_id] = 1'b0;
            if ($urandom_range(0, 999) == 0) begin
                reset_n = 1'b0;
                @(posedge clk);
                #1 reset_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
